mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
// Parametrised MEM pipeline stage of the MIPS datapath, between EX/MEM and WB. Talks to external
// data memory over a req/ack handshake, stalling upstream until the access completes. Applies
// byte/half/word lane steering and sign/zero extension, and flags misaligned and timed-out
// accesses. Drives the MEM/WB register and resolves branches (PCSrc).
// PARAMETERS
// ADDR_W       11  byte-address width used from alu_result (memory = 2^ADDR_W bytes)
// REG_W        5   register-destination index width
// TIMEOUT_CYC  16  max WAIT cycles without mem_ack before abort (>=1)
// PORTS
// clock          in   1         rising-edge clock
// reset_n        in   1         asynchronous, active-low reset
// in_valid       in   1         EX/MEM holds a valid instruction
// stall_out      out  1         upstream must hold its inputs this cycle
// MemRead/MemWrite/Branch in 1 each  control from EX/MEM
// trunk_mode     in   3         000 W, 001 HU, 010 HS, 011 BU, 100 BS; others = W
// zero_signal    in   1         ALU zero flag
// alu_result     in   32        address / ALU result
// in_data        in   32        store data
// reg_dest       in   REG_W     destination register
// MemToReg_in/RegWrite_in in 1 each  WB control
// mem_req        out  1         memory request; held until mem_ack
// mem_we         out  1         1 = write
// mem_addr       out  ADDR_W-2  word address = alu_result[ADDR_W-1:2]
// mem_wdata      out  32        lane-replicated store data
// mem_be         out  4         byte enables
// mem_ack        in   1         access done; mem_rdata valid this cycle for reads
// mem_rdata      in   32        raw read word
// out_valid      out  1         MEM/WB entry valid
// read_data_out/alu_result_out out 32  MEM/WB data
// reg_dest_out   out  REG_W     MEM/WB destination
// MemToReg_out/RegWrite_out out 1     MEM/WB control
// exc_misalign/exc_timeout out 1      MEM/WB exception flags
// PCSrc          out  1         in_valid & Branch & zero_signal & state==IDLE (combinational)
// BEHAVIOUR
// - Reset: state IDLE, timeout counter 0, every registered output 0; mem_req/stall_out 0 at once.
// - Memory op = in_valid & (MemRead|MemWrite); MemRead wins if both set. Misaligned: W with
//   addr[1:0]!=0, or H with addr[0]=1.
// - IDLE: non-mem instruction or bubble -> MEM/WB loads next edge (latency 1), no stall.
//   Misaligned op -> no request; MEM/WB loads with RegWrite_out=0, MemToReg_out=0,
//   exc_misalign=1. Aligned op -> stall_out=1 combinationally, operands captured, go WAIT.
// - WAIT: mem_req=1 driven from captured operands; stall_out=1 except in the mem_ack cycle.
//   Counter increments each WAIT cycle. mem_ack -> MEM/WB loads, out_valid=1, go IDLE.
//   Counter reaches TIMEOUT_CYC without ack -> mem_req drops, MEM/WB loads with RegWrite_out=0,
//   exc_timeout=1, go IDLE. If ack and timeout coincide, the ack wins and completes normally.
// - mem_ack outside WAIT is ignored. Inputs during WAIT are ignored; upstream holds them.
// - Store: byte mem_be=4'b0001<<addr[1:0], wdata={4{d[7:0]}}; half 4'b0011<<addr[1:0],
//   {2{d[15:0]}}; word 4'b1111, d. Loads: mem_be=4'b1111.
// - Load: select lane by addr[1:0]; S modes sign-extend, U modes zero-extend.
// - MEM/WB updates every cycle. With no completion: out_valid=0, RegWrite_out=0,
//   MemToReg_out=0, exc_*=0; data fields hold their previous value.
// - Reset mid-WAIT: the transaction is abandoned and no MEM/WB entry is produced.
// TESTING
// 1 LW addr 0x010, ack 3 cycles after mem_req, rdata 0x8899AABB -> stall_out 1 for 3 cycles,
//   then 0 in the ack cycle; read_data_out=0x8899AABB; out_valid pulses for 1 cycle.
// 2 rdata 0x80112233: LBS @0x013 -> 0xFFFFFF80; LBU @0x013 -> 0x00000080;
//   LHU @0x012 -> 0x00008011; LHS @0x010 -> 0x00002233.
// 3 SB @0x021 data 0x000000A5 -> mem_we=1, mem_be=4'b0010, mem_wdata=0xA5A5A5A5;
//   SH @0x022 data 0x1234 -> mem_be=4'b1100, mem_wdata=0x12341234.
// 4 LW @0x022 -> no mem_req, no stall, exc_misalign=1, RegWrite_out=0 next cycle.
// 5 TIMEOUT_CYC=8, no ack -> mem_req drops after 8 WAIT cycles, exc_timeout=1;
//   repeat with ack in WAIT cycle 8 -> normal completion, exc_timeout=0.
// 6 reset_n low in WAIT -> mem_req/stall_out/out_valid 0 immediately. After release, an ALU op
//   completes in 1 cycle; Branch=1 & zero=1 -> PCSrc=1 in the same cycle.

Source files
------------

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : MEM stage of the MIPS datapath, sitting between EX/MEM and MEM/WB.
//            Performs loads/stores through a req/ack data-memory handshake and
//            stalls upstream while an access is outstanding. Steers byte/half/
//            word lanes, sign/zero extends loads, and flags misaligned or
//            timed-out accesses. Drives the MEM/WB register and PCSrc.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock, reset_n        rising-edge clock, async active-low reset
//   in_valid              EX/MEM holds a valid instruction
//   stall_out             upstream must hold its inputs this cycle
//   MemRead/MemWrite/Branch, trunk_mode, zero_signal   EX/MEM control
//   alu_result, in_data, reg_dest, MemToReg_in, RegWrite_in   EX/MEM data
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be   data-memory request
//   mem_ack/mem_rdata     data-memory response
//   out_valid, read_data_out, alu_result_out, reg_dest_out,
//   MemToReg_out, RegWrite_out, exc_misalign, exc_timeout   MEM/WB register
//   PCSrc                 branch taken (combinational)
// ============================================================================
module mem_access_stage #(
  parameter int ADDR_W      = 11,
  parameter int REG_W       = 5,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              stall_out,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              Branch,
  input  logic [2:0]        trunk_mode,
  input  logic              zero_signal,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       in_data,
  input  logic [REG_W-1:0]  reg_dest,
  input  logic              MemToReg_in,
  input  logic              RegWrite_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  output logic [31:0]       read_data_out,
  output logic [31:0]       alu_result_out,
  output logic [REG_W-1:0]  reg_dest_out,
  output logic              MemToReg_out,
  output logic              RegWrite_out,
  output logic              exc_misalign,
  output logic              exc_timeout,
  output logic              PCSrc
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Operands captured when an access is launched
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              half_q, half_d;
  logic              byte_q, byte_d;
  logic              sign_q, sign_d;
  logic [31:0]       alu_cap_q, alu_cap_d;
  logic [REG_W-1:0]  dest_cap_q, dest_cap_d;
  logic              m2r_cap_q, m2r_cap_d;
  logic              rw_cap_q, rw_cap_d;

  // MEM/WB register
  logic              out_valid_q, out_valid_d;
  logic [31:0]       read_data_q, read_data_d;
  logic [31:0]       alu_out_q, alu_out_d;
  logic [REG_W-1:0]  dest_out_q, dest_out_d;
  logic              m2r_out_q, m2r_out_d;
  logic              rw_out_q, rw_out_d;
  logic              mis_q, mis_d;
  logic              to_q, to_d;

  logic              is_mem, is_half, is_byte, is_sign, misaligned, stall;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata, rd_shifted, load_ext;

  // Access size decode; undefined modes behave as word
  always_comb begin
    is_half = (trunk_mode == 3'b001) || (trunk_mode == 3'b010);
    is_byte = (trunk_mode == 3'b011) || (trunk_mode == 3'b100);
    is_sign = (trunk_mode == 3'b010) || (trunk_mode == 3'b100);
    is_mem  = in_valid & (MemRead | MemWrite);
    if (is_byte)      misaligned = 1'b0;
    else if (is_half) misaligned = alu_result[0];
    else              misaligned = (alu_result[1:0] != 2'b00);
  end

  // Store lane steering: data replicated across lanes, enables pick the lane
  always_comb begin
    if (is_byte) begin
      st_be    = 4'b0001 << alu_result[1:0];
      st_wdata = {4{in_data[7:0]}};
    end else if (is_half) begin
      st_be    = 4'b0011 << alu_result[1:0];
      st_wdata = {2{in_data[15:0]}};
    end else begin
      st_be    = 4'b1111;
      st_wdata = in_data;
    end
  end

  // Load lane select from the captured address, then extend
  always_comb begin
    rd_shifted = mem_rdata >> {addr_q[1:0], 3'b000};
    if (byte_q)      load_ext = sign_q ? {{24{rd_shifted[7]}}, rd_shifted[7:0]}
                                       : {24'd0, rd_shifted[7:0]};
    else if (half_q) load_ext = sign_q ? {{16{rd_shifted[15]}}, rd_shifted[15:0]}
                                       : {16'd0, rd_shifted[15:0]};
    else             load_ext = mem_rdata;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    half_d      = half_q;
    byte_d      = byte_q;
    sign_d      = sign_q;
    alu_cap_d   = alu_cap_q;
    dest_cap_d  = dest_cap_q;
    m2r_cap_d   = m2r_cap_q;
    rw_cap_d    = rw_cap_q;
    out_valid_d = 1'b0;
    read_data_d = read_data_q;
    alu_out_d   = alu_out_q;
    dest_out_d  = dest_out_q;
    m2r_out_d   = 1'b0;
    rw_out_d    = 1'b0;
    mis_d       = 1'b0;
    to_d        = 1'b0;
    stall       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_mem && misaligned) begin
          out_valid_d = 1'b1;
          alu_out_d   = alu_result;
          dest_out_d  = reg_dest;
          mis_d       = 1'b1;
        end else if (is_mem) begin
          stall      = 1'b1;
          state_d    = S_WAIT;
          cnt_d      = '0;
          addr_d     = alu_result[ADDR_W-1:0];
          we_d       = ~MemRead;               // read wins when both set
          be_d       = MemRead ? 4'b1111 : st_be;
          wdata_d    = st_wdata;
          half_d     = is_half;
          byte_d     = is_byte;
          sign_d     = is_sign;
          alu_cap_d  = alu_result;
          dest_cap_d = reg_dest;
          m2r_cap_d  = MemToReg_in;
          rw_cap_d   = RegWrite_in;
        end else if (in_valid) begin
          out_valid_d = 1'b1;
          alu_out_d   = alu_result;
          dest_out_d  = reg_dest;
          m2r_out_d   = MemToReg_in;
          rw_out_d    = RegWrite_in;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_ack) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b1;
          alu_out_d   = alu_cap_q;
          dest_out_d  = dest_cap_q;
          m2r_out_d   = m2r_cap_q;
          rw_out_d    = rw_cap_q;
          if (!we_q) read_data_d = load_ext;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          // Last allowed WAIT cycle without ack: abort and release upstream
          state_d     = S_IDLE;
          out_valid_d = 1'b1;
          alu_out_d   = alu_cap_q;
          dest_out_d  = dest_cap_q;
          to_d        = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      half_q      <= 1'b0;
      byte_q      <= 1'b0;
      sign_q      <= 1'b0;
      alu_cap_q   <= '0;
      dest_cap_q  <= '0;
      m2r_cap_q   <= 1'b0;
      rw_cap_q    <= 1'b0;
      out_valid_q <= 1'b0;
      read_data_q <= '0;
      alu_out_q   <= '0;
      dest_out_q  <= '0;
      m2r_out_q   <= 1'b0;
      rw_out_q    <= 1'b0;
      mis_q       <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      half_q      <= half_d;
      byte_q      <= byte_d;
      sign_q      <= sign_d;
      alu_cap_q   <= alu_cap_d;
      dest_cap_q  <= dest_cap_d;
      m2r_cap_q   <= m2r_cap_d;
      rw_cap_q    <= rw_cap_d;
      out_valid_q <= out_valid_d;
      read_data_q <= read_data_d;
      alu_out_q   <= alu_out_d;
      dest_out_q  <= dest_out_d;
      m2r_out_q   <= m2r_out_d;
      rw_out_q    <= rw_out_d;
      mis_q       <= mis_d;
      to_q        <= to_d;
    end
  end

  // Stall is gated by reset so upstream is released the moment reset asserts
  assign stall_out      = stall & reset_n;
  assign mem_req        = (state_q == S_WAIT);
  assign mem_we         = we_q & (state_q == S_WAIT);
  assign mem_addr       = addr_q[ADDR_W-1:2];
  assign mem_wdata      = wdata_q;
  assign mem_be         = be_q;
  assign out_valid      = out_valid_q;
  assign read_data_out  = read_data_q;
  assign alu_result_out = alu_out_q;
  assign reg_dest_out   = dest_out_q;
  assign MemToReg_out   = m2r_out_q;
  assign RegWrite_out   = rw_out_q;
  assign exc_misalign   = mis_q;
  assign exc_timeout    = to_q;
  assign PCSrc          = in_valid & Branch & zero_signal & (state_q == S_IDLE);

endmodule
`default_nettype wire
